// File: rtl/dataram_pkg.sv
// Shared types and helpers for the DATARAM initiator: op codes, FSM states, bit-address decode.
package dataram_pkg;

    typedef enum logic [2:0] {
        OpRdByte = 3'b000,
        OpWrByte = 3'b001,
        OpRdBit  = 3'b010,
        OpWrBit  = 3'b011,
        OpRdRn   = 3'b100,
        OpWrRn   = 3'b101,
        OpRdInd  = 3'b110,
        OpWrInd  = 3'b111
    } op_e;

    // op[2:1] selects the addressing mode, op[0] is the write flag
    typedef enum logic [1:0] {
        KindByte = 2'b00,
        KindBit  = 2'b01,
        KindRn   = 2'b10,
        KindInd  = 2'b11
    } kind_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StPtr  = 2'b01,
        StAcc  = 2'b10,
        StRsp  = 2'b11
    } state_e;

    localparam logic [7:0] BIT_AREA_BASE = 8'h20;
    localparam logic [7:0] SFR_BIT_BASE  = 8'h80;

    // Low bit addresses map into the 0x20..0x2F bit area; high ones into bit-addressable SFRs.
    function automatic logic [7:0] bitaddr_to_byte(input logic [7:0] bit_addr);
        if (bit_addr < SFR_BIT_BASE) begin
            return BIT_AREA_BASE + {4'b0000, bit_addr[6:3]};
        end
        return {bit_addr[7:3], 3'b000};
    endfunction

endpackage

// File: rtl/dataram_bitdec.sv
// Combinational bit-address decoder: bit address -> byte address and one-hot bit position.
module dataram_bitdec
    import dataram_pkg::*;
(
    input  logic [7:0] bit_addr_i,
    output logic [7:0] byte_addr_o,
    output logic [7:0] position_o
);

    assign byte_addr_o = bitaddr_to_byte(bit_addr_i);
    assign position_o  = 8'b0000_0001 << bit_addr_i[2:0];

endmodule

// File: rtl/dataram_ctrl.sv
// DATARAM initiator: one CPU request at a time (byte/bit/Rn/@Ri), drives the RAM CS sequence.
// Build option: DATARAM_CTRL_INDIRECT_EN enables the @Ri pointer fetch; otherwise @Ri ops abort.
module dataram_ctrl
    import dataram_pkg::*;
#(
    parameter int unsigned RD_LAT   = 1,
    parameter logic [7:0]  IRAM_TOP = 8'h7F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    input  logic [7:0] req_arg,
    input  logic [7:0] req_wdata,
    input  logic       req_wbit,
    input  logic [1:0] rs,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_bit,
    output logic       rsp_err,
    output logic       mem_cs_n,
    output logic       mem_rw,
    output logic       mem_bb,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_position,
    output logic [7:0] mem_din,
    output logic       mem_bin,
    input  logic [7:0] mem_dout,
    input  logic       mem_bout
);

    localparam int unsigned RdLat   = (RD_LAT == 0) ? 1 : RD_LAT;
    localparam logic [7:0]  LastCnt = 8'(RdLat - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] ptr_q, ptr_d;
    logic       err_q, err_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rbit_q, rbit_d;
    logic       rdy_q;

    op_e        op_q;
    logic [7:0] arg_q, wdata_q;
    logic       wbit_q;
    logic [1:0] rs_q;

    logic       is_wr;
    kind_e      kind;
    logic [7:0] bit_byte, bit_pos;

    assign is_wr    = op_q[0];
    assign kind     = kind_e'(op_q[2:1]);
    assign rsp_data = rdata_q;
    assign rsp_bit  = rbit_q;

    dataram_bitdec u_bitdec (
        .bit_addr_i  (arg_q),
        .byte_addr_o (bit_byte),
        .position_o  (bit_pos)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            rbit_q  <= 1'b0;
            rdy_q   <= 1'b0;
            op_q    <= OpRdByte;
            arg_q   <= '0;
            wdata_q <= '0;
            wbit_q  <= 1'b0;
            rs_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rbit_q  <= rbit_d;
            rdy_q   <= 1'b1;
            if (req_valid && req_ready) begin
                op_q    <= op_e'(req_op);
                arg_q   <= req_arg;
                wdata_q <= req_wdata;
                wbit_q  <= req_wbit;
                rs_q    <= rs;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        err_d        = err_q;
        rdata_d      = rdata_q;
        rbit_d       = rbit_q;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_err      = 1'b0;
        mem_cs_n     = 1'b1;
        mem_rw       = 1'b1;
        mem_bb       = 1'b1;
        mem_addr     = '0;
        mem_position = '0;
        mem_din      = '0;
        mem_bin      = 1'b0;

        unique case (state_q)
            StIdle: begin
                req_ready = rdy_q;
                if (req_valid && rdy_q) begin
                    err_d = 1'b0;
                    cnt_d = '0;
                    if (kind_e'(req_op[2:1]) == KindInd) begin
`ifdef DATARAM_CTRL_INDIRECT_EN
                        state_d = StPtr;
`else
                        state_d = StRsp;
                        err_d   = 1'b1;
`endif
                    end else begin
                        state_d = StAcc;
                    end
                end
            end
            StPtr: begin
                mem_cs_n = 1'b0;
                mem_addr = {3'b000, rs_q, 2'b00, arg_q[0]};
                if (cnt_q == LastCnt) begin
                    cnt_d = '0;
                    ptr_d = mem_dout;
                    // An out-of-range pointer never reaches the bus
                    if (mem_dout > IRAM_TOP) begin
                        err_d   = 1'b1;
                        state_d = StRsp;
                    end else begin
                        state_d = StAcc;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StAcc: begin
                mem_cs_n = 1'b0;
                mem_rw   = ~is_wr;
                unique case (kind)
                    KindByte: mem_addr = arg_q;
                    KindBit: begin
                        mem_bb       = 1'b0;
                        mem_addr     = bit_byte;
                        mem_position = bit_pos;
                    end
                    KindRn:   mem_addr = {3'b000, rs_q, arg_q[2:0]};
                    KindInd:  mem_addr = ptr_q;
                endcase
                if (is_wr) begin
                    if (kind == KindBit) mem_bin = wbit_q;
                    else                 mem_din = wdata_q;
                end
                if (is_wr || cnt_q == LastCnt) begin
                    cnt_d   = '0;
                    state_d = StRsp;
                    if (!is_wr) begin
                        rdata_d = mem_dout;
                        rbit_d  = mem_bout;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StRsp: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                state_d   = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_dataram_ctrl.sv
// Bench for dataram_ctrl: transaction-level model predicts every bus/response cycle; RAM is behavioural.
module tb_dataram_ctrl;

    localparam int LAT = 2;
    localparam logic [2:0] RD_BYTE = 3'b000, WR_BYTE = 3'b001, RD_BIT = 3'b010, WR_BIT = 3'b011;
    localparam logic [2:0] RD_RN = 3'b100, WR_RN = 3'b101, RD_IND = 3'b110, WR_IND = 3'b111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0, req_ready;
    logic [2:0] req_op = 3'b000;
    logic [7:0] req_arg = 8'h00, req_wdata = 8'h00;
    logic       req_wbit = 1'b0;
    logic [1:0] rs = 2'b00;
    logic       rsp_valid, rsp_bit, rsp_err;
    logic [7:0] rsp_data;
    logic       mem_cs_n, mem_rw, mem_bb, mem_bin, mem_bout;
    logic [7:0] mem_addr, mem_position, mem_din, mem_dout;

    dataram_ctrl #(.RD_LAT(LAT), .IRAM_TOP(8'h7F)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_arg(req_arg), .req_wdata(req_wdata), .req_wbit(req_wbit), .rs(rs),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_bit(rsp_bit), .rsp_err(rsp_err),
        .mem_cs_n(mem_cs_n), .mem_rw(mem_rw), .mem_bb(mem_bb), .mem_addr(mem_addr),
        .mem_position(mem_position), .mem_din(mem_din), .mem_bin(mem_bin),
        .mem_dout(mem_dout), .mem_bout(mem_bout)
    );

    always #5 clk = ~clk;

    // Behavioural DATARAM
    logic [7:0] ram [256];
    assign mem_dout = (!mem_cs_n && mem_rw) ? ram[mem_addr] : 8'h00;
    assign mem_bout = (!mem_cs_n && mem_rw) ? |(ram[mem_addr] & mem_position) : 1'b0;
    always @(posedge clk) begin
        if (!mem_cs_n && !mem_rw) begin
            if (mem_bb) ram[mem_addr] <= mem_din;
            else if (mem_bin) ram[mem_addr] <= ram[mem_addr] | mem_position;
            else ram[mem_addr] <= ram[mem_addr] & ~mem_position;
        end
    end

    typedef struct packed {
        logic       cs_n, rw, bb;
        logic [7:0] addr, pos, din;
        logic       bin, rv, re;
    } bus_t;
    typedef struct {
        bus_t       bus;
        logic [7:0] data;
        logic       bitv;
    } step_t;

    step_t      exp_q[$];
    logic [7:0] mdl [256];
    logic [7:0] held_data = 8'h00;
    logic       held_bit = 1'b0;
    int         errors = 0, checks = 0;
    logic       mon_en = 1'b0;
    int         ncyc, cs_cnt, rsp_at;
    logic [7:0] cs_first, cs_last, din_last, pos_last;
    logic       bb_last, err_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bus_t idle_bus();
        bus_t b;
        b = '0;
        b.cs_n = 1'b1;
        b.rw = 1'b1;
        b.bb = 1'b1;
        return b;
    endfunction

    // Transaction model: appends the expected per-cycle bus picture and updates the model RAM.
    task automatic plan(input logic [2:0] op, input logic [7:0] arg, input logic [7:0] wd,
                        input logic wb, input logic [1:0] rsel);
        step_t      s;
        logic       wr, err;
        logic [7:0] a, pos;
        wr = op[0];
        err = 1'b0;
        pos = 8'h00;
        a = 8'h00;
        s.data = held_data;
        s.bitv = held_bit;
        if (op[2:1] == 2'b11) begin
`ifdef DATARAM_CTRL_INDIRECT_EN
            s.bus = idle_bus();
            s.bus.cs_n = 1'b0;
            s.bus.addr = 8'(int'(rsel) * 8 + int'(arg[0]));
            for (int i = 0; i < LAT; i++) exp_q.push_back(s);
            a = mdl[s.bus.addr];
            err = (a > 8'h7F);
`else
            err = 1'b1;
`endif
        end else if (op[2:1] == 2'b00) begin
            a = arg;
        end else if (op[2:1] == 2'b01) begin
            a = (arg < 8'h80) ? 8'(32 + int'(arg) / 8) : 8'(int'(arg) / 8 * 8);
            pos = 8'(1 << (int'(arg) % 8));
        end else begin
            a = 8'(int'(rsel) * 8 + int'(arg) % 8);
        end
        if (!err) begin
            s.bus = idle_bus();
            s.bus.cs_n = 1'b0;
            s.bus.rw = !wr;
            s.bus.bb = (op[2:1] != 2'b01);
            s.bus.addr = a;
            s.bus.pos = pos;
            if (wr && op[2:1] == 2'b01) s.bus.bin = wb;
            else if (wr) s.bus.din = wd;
            for (int i = 0; i < (wr ? 1 : LAT); i++) exp_q.push_back(s);
            if (!wr) begin
                held_data = mdl[a];
                held_bit = |(mdl[a] & pos);
            end else if (op[2:1] == 2'b01) begin
                mdl[a] = wb ? (mdl[a] | pos) : (mdl[a] & ~pos);
            end else begin
                mdl[a] = wd;
            end
        end
        s.bus = idle_bus();
        s.bus.rv = 1'b1;
        s.bus.re = err;
        s.data = held_data;
        s.bitv = held_bit;
        exp_q.push_back(s);
    endtask

    task automatic run(input logic [2:0] op, input logic [7:0] arg, input logic [7:0] wd,
                       input logic wb, input logic [1:0] rsel);
        int guard;
        req_op = op;
        req_arg = arg;
        req_wdata = wd;
        req_wbit = wb;
        rs = rsel;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        plan(op, arg, wd, wb, rsel);
        ncyc = 0;
        cs_cnt = 0;
        rsp_at = -1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            @(posedge clk);
            guard++;
        end
        #1;
        chk("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Compare process plus a small bus monitor for the hand-computed pins
    always @(negedge clk) begin
        step_t e;
        ncyc++;
        if (!mem_cs_n) begin
            if (cs_cnt == 0) cs_first = mem_addr;
            cs_cnt++;
            cs_last = mem_addr;
            din_last = mem_din;
            pos_last = mem_position;
            bb_last = mem_bb;
        end
        if (rsp_valid) begin
            rsp_at = ncyc;
            err_last = rsp_err;
        end
        if (mon_en) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("bus", {2'b00, mem_cs_n, mem_rw, mem_bb, mem_addr, mem_position, mem_din,
                            mem_bin, rsp_valid, rsp_err}, {2'b00, e.bus});
                if (e.bus.rv) chk("rsp_rdata", {rsp_bit, rsp_data}, {e.bitv, e.data});
            end else begin
                chk("idle", {rsp_valid, mem_cs_n, req_ready}, 3'b011);
            end
        end
    end

    initial begin
        bus_t rb;
        for (int i = 0; i < 256; i++) begin
            ram[i] = 8'(i) ^ 8'h5A;
            mdl[i] = 8'(i) ^ 8'h5A;
        end
        #12;
        rb = idle_bus();
        chk("reset_bus", {2'b00, mem_cs_n, mem_rw, mem_bb, mem_addr, mem_position, mem_din,
                          mem_bin, rsp_valid, rsp_err}, {2'b00, rb});
        chk("reset_rsp", {req_ready, rsp_bit, rsp_data}, 10'h000);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", req_ready, 1'b1);
        mon_en = 1'b1;

        run(WR_BYTE, 8'h30, 8'h55, 1'b0, 2'b00);
        chk("wrbyte_pins", {cs_cnt[7:0], cs_first, din_last, rsp_at[7:0]}, 32'h01_30_55_02);
        chk("wrbyte_ram", ram[8'h30], 8'h55);
        run(WR_RN, 8'h07, 8'hA5, 1'b0, 2'b01);
        chk("wrrn_addr", cs_first, 8'h0F);
        run(RD_RN, 8'h07, 8'h00, 1'b0, 2'b01);
        chk("rdrn_pins", {cs_first, rsp_data, rsp_at[7:0]}, 24'h0F_A5_03);
        run(WR_BIT, 8'h02, 8'h00, 1'b1, 2'b00);
        run(RD_BIT, 8'h02, 8'h00, 1'b0, 2'b00);
        chk("rdbit_pins", {cs_first, pos_last, 7'b0, bb_last, 7'b0, rsp_bit}, 32'h2004_0001);
        run(RD_BIT, 8'hE3, 8'h00, 1'b0, 2'b00);
        chk("rdbit_sfr", {cs_first, pos_last}, 16'hE008);
        run(WR_BIT, 8'h7F, 8'h00, 1'b0, 2'b00);
        chk("wrbit_7f", {cs_first, pos_last}, 16'h2F80);
        run(RD_BYTE, 8'h2F, 8'h00, 1'b0, 2'b00);
        run(WR_BIT, 8'h80, 8'h00, 1'b0, 2'b00);
        chk("wrbit_80", {cs_first, pos_last}, 16'h8001);
        run(WR_BYTE, 8'hC4, 8'h3E, 1'b0, 2'b00);
        run(RD_BYTE, 8'hC4, 8'h00, 1'b0, 2'b00);

        run(WR_RN, 8'h00, 8'h07, 1'b0, 2'b00);
        run(WR_RN, 8'h01, 8'h90, 1'b0, 2'b00);
        run(WR_RN, 8'h01, 8'h7F, 1'b0, 2'b10);
        run(RD_IND, 8'h00, 8'h00, 1'b0, 2'b00);
`ifdef DATARAM_CTRL_INDIRECT_EN
        chk("ind_pins", {cs_first, cs_last, cs_cnt[7:0], rsp_at[7:0]}, 32'h00_07_04_05);
`else
        chk("ind_off_pins", {cs_cnt[7:0], rsp_at[7:0], 7'b0, err_last}, 24'h00_01_01);
`endif
        run(RD_IND, 8'h01, 8'h00, 1'b0, 2'b00);
`ifdef DATARAM_CTRL_INDIRECT_EN
        chk("ind_bad_ptr", {cs_cnt[7:0], rsp_at[7:0], 7'b0, err_last}, 24'h02_03_01);
`else
        chk("ind_off_err", {cs_cnt[7:0], 7'b0, err_last}, 16'h0001);
`endif
        run(WR_IND, 8'h01, 8'h3C, 1'b0, 2'b10);
        run(RD_BYTE, 8'h7F, 8'h00, 1'b0, 2'b00);

        // Reset while the ACC strobe is low
        mon_en = 1'b0;
        req_op = RD_BYTE;
        req_arg = 8'h44;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("pre_reset_cs", mem_cs_n, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("reset_abort", {mem_cs_n, rsp_valid, req_ready}, 3'b100);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        held_data = 8'h00;
        held_bit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", {rsp_valid, mem_cs_n}, 2'b01);
        end
        @(posedge clk);
        #1;
        chk("ready_after_abort", req_ready, 1'b1);
        mon_en = 1'b1;
        run(RD_BYTE, 8'h30, 8'h00, 1'b0, 2'b00);
        chk("recover_read", rsp_data, 8'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
